spi_cmd: RTL and testbench
==========================

Name: spi_cmd

Overview:
- Downstream consumer of spi_byte. Runs in the system clock domain.
- Turns the stream of received SPI bytes into single-byte bus read/write requests for the PET RAM/IO bus.
- Uses a req/ack handshake on the bus side and returns read data to spi_byte's tx input for the next SPI byte.
- Synchronizes spi_byte's sclk-domain done and spi_cs_n into clk.

Parameters:
- ADDR_WIDTH, 17, bus address width. Legal range 16..17. Bit 16, if present, comes from cmd[0].

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- spi_cs_n  input  1  SPI chip select, async to clk, low = transaction active
- rx_done  input  1  spi_byte done, async to clk, high after 8th bit
- rx  input  8  spi_byte received byte; stable while rx_done high
- tx  output  8  byte for spi_byte to shift out on the next SPI byte
- addr  output  ADDR_WIDTH  bus address
- wr_data  output  8  bus write data
- we  output  1  1 = write, 0 = read; valid while req high
- req  output  1  bus request, held until ack
- ack  input  1  one-clk pulse completing the request
- rd_data  input  8  bus read data, valid on the ack cycle
- overrun  output  1  sticky overrun flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE, addr=0, wr_data=0, we=0, req=0, tx=0, overrun=0. Sync flops=idle values (done=1, cs_n=1).
- Sync: 2-FF synchronizers on rx_done and spi_cs_n, plus one edge register.
- Byte strobe = rising edge of synced done. rx is sampled on that cycle, 3 clk after rx_done rises.
- SCLK period must be >= 8 clk periods.
- Synced cs_n high forces state=IDLE on the next clk, unless state=BUS; BUS completes first, then goes to IDLE.
- A new transaction starts only at IDLE with cs_n low.
- Command byte (first byte after cs_n falls): op=cmd[7:5]; cmd[0]=addr[16] when ADDR_WIDTH=17.
  - 000 WRITE_AT -> ADDR_HI, ADDR_LO, DATA.
  - 001 READ_AT -> ADDR_HI, ADDR_LO, then BUS (read).
  - 010 WRITE_NEXT -> addr=addr+1, then DATA.
  - 011 READ_NEXT -> addr=addr+1, then BUS (read) on the command-byte strobe.
  - others -> IGNORE until cs_n high.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, BUS, IGNORE.
- ADDR_HI strobe: addr[15:8]=rx. ADDR_LO strobe: addr[7:0]=rx.
- DATA strobe: wr_data=rx, we=1, go to BUS.
- After a write: further data bytes in the same cs_n frame auto-increment (addr+1) and write again (burst).
- BUS: req=1 the cycle after entry.
  - On ack: req=0 the following cycle.
  - For a read, tx=rd_data; the host clocks one dummy byte to receive it.
  - Next state: DATA for write bursts, IGNORE for reads. Reads are single-byte per frame unless reissued with READ_NEXT in a new frame.
- Address arithmetic: increment wraps modulo 2^ADDR_WIDTH (0x1FFFF+1 -> 0x00000).
- Byte strobe while in BUS: byte is dropped and state is unchanged.
- ack while req=0: ignored.
- tx holds its last value except on a read ack.
- Reset mid-operation: req drops immediately (async); the bus must tolerate an abandoned request.

Optional Feature:
- Macro SPI_CMD_OVERRUN_EN.
- Defined: a byte strobe while in BUS sets overrun=1 (sticky). Cleared on the clk after synced cs_n falls (start of the next frame), or by reset.
- Undefined: overrun is tied 0, no flop is inferred, and dropped bytes are silent.

Test Plan:
- WRITE_AT cmd=0x01, bytes 0x23,0x45,0xA5 -> one req with addr=0x12345, we=1, wr_data=0xA5. req held until ack, drops next clk.
- WRITE_AT addr 0x1FFFF, data 0x11,0x22 in one frame -> writes 0x11@0x1FFFF, then 0x22@0x00000 (wrap).
- READ_AT cmd=0x20, 0x80,0x00; ack with rd_data=0x5A -> req we=0 addr=0x08000, tx=0x5A after ack. Dummy byte clocks 0x5A out of the paired spi_byte.
- READ_NEXT cmd=0x60 after the previous test -> read at 0x08001 with no address bytes.
- Undefined cmd 0xE0 then bytes 0x00,0x00 -> no req. cs_n high then WRITE_NEXT works normally.
- cs_n raised mid-address (after ADDR_HI), reset pulsed during BUS, and (with SPI_CMD_OVERRUN_EN) a byte sent while ack withheld:
  - mid-address cs_n -> IDLE, no req.
  - reset during BUS -> req=0 immediately.
  - byte during withheld ack -> overrun=1 until next cs_n fall.

Source files
------------

// File: rtl/spi_cmd.sv
// spi_cmd: turns received SPI bytes into single-byte bus read/write requests.
// Latency: byte strobe 3 clk after rx_done rises; req rises 2 clk after the strobe that completes a command.
// Backpressure: req is held until ack; bytes arriving while a request is outstanding are dropped.
//
// Ports:
//   clk, reset            system clock, async active-high reset (sync release expected upstream)
//   spi_cs_n, rx_done, rx from spi_byte (cs_n/done async to clk, rx stable while done high)
//   tx                    byte returned to spi_byte for the next SPI byte (read data)
//   addr, wr_data, we,
//   req, ack, rd_data     single-byte req/ack bus toward PET RAM/IO
//   overrun               sticky dropped-byte flag
//
// Optional feature: define SPI_CMD_OVERRUN_EN to enable the sticky overrun flag;
// when undefined, overrun is tied 0.

module spi_cmd #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_cs_n,
  input  logic                  rx_done,
  input  logic [7:0]            rx,
  output logic [7:0]            tx,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            wr_data,
  output logic                  we,
  output logic                  req,
  input  logic                  ack,
  input  logic [7:0]            rd_data,
  output logic                  overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_BUS, S_IGNORE
  } state_t;

  // Bit 16 of the address; truncates to zero for a 16-bit bus.
  localparam logic [ADDR_WIDTH-1:0] LP_B16 = ADDR_WIDTH'(32'h0001_0000);

  state_t                r_state, w_state_nxt;
  logic                  r_done_s1, r_done_s2, r_done_d;
  logic                  r_cs_s1, r_cs_s2;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt, w_addr_inc, w_addr_cmd;
  logic [7:0]            r_wr_data, w_wr_data_nxt;
  logic [7:0]            r_tx, w_tx_nxt;
  logic                  r_we, w_we_nxt;
  logic                  r_req, w_req_nxt;
  logic                  r_burst, w_burst_nxt;   // next data byte auto-increments
  logic                  r_is_read, w_is_read_nxt;
  logic                  w_strobe, w_cs_high;

  // Synchronizers idle at 1 so a reset release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done_s1 <= 1'b1;
      r_done_s2 <= 1'b1;
      r_done_d  <= 1'b1;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
    end else begin
      r_done_s1 <= rx_done;
      r_done_s2 <= r_done_s1;
      r_done_d  <= r_done_s2;
      r_cs_s1   <= spi_cs_n;
      r_cs_s2   <= r_cs_s1;
    end
  end

  assign w_strobe   = r_done_s2 & ~r_done_d;
  assign w_cs_high  = r_cs_s2;
  assign w_addr_inc = r_addr + ADDR_WIDTH'(1);
  // Command byte only supplies bit 16; the lower bits come from the address bytes.
  assign w_addr_cmd = rx[0] ? (r_addr | LP_B16) : (r_addr & ~LP_B16);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_tx      <= '0;
      r_we      <= 1'b0;
      r_req     <= 1'b0;
      r_burst   <= 1'b0;
      r_is_read <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_tx      <= w_tx_nxt;
      r_we      <= w_we_nxt;
      r_req     <= w_req_nxt;
      r_burst   <= w_burst_nxt;
      r_is_read <= w_is_read_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wr_data_nxt = r_wr_data;
    w_tx_nxt      = r_tx;
    w_we_nxt      = r_we;
    w_req_nxt     = r_req;
    w_burst_nxt   = r_burst;
    w_is_read_nxt = r_is_read;

    if (r_state == S_BUS) begin
      // BUS always completes, even if cs_n has gone high; strobes here are dropped.
      if (r_req && ack) begin
        w_req_nxt = 1'b0;
        if (r_we) begin
          w_burst_nxt = 1'b1;
          w_state_nxt = w_cs_high ? S_IDLE : S_DATA;
        end else begin
          w_tx_nxt    = rd_data;
          w_state_nxt = w_cs_high ? S_IDLE : S_IGNORE;
        end
      end else if (!r_req) begin
        w_req_nxt = 1'b1;
      end
    end else if (w_cs_high) begin
      w_state_nxt = S_IDLE;
    end else if (w_strobe) begin
      case (r_state)
        S_IDLE: begin
          case (rx[7:5])
            3'b000: begin
              w_addr_nxt    = w_addr_cmd;
              w_is_read_nxt = 1'b0;
              w_burst_nxt   = 1'b0;
              w_state_nxt   = S_ADDR_HI;
            end
            3'b001: begin
              w_addr_nxt    = w_addr_cmd;
              w_is_read_nxt = 1'b1;
              w_state_nxt   = S_ADDR_HI;
            end
            3'b010: begin
              w_addr_nxt  = w_addr_inc;
              w_burst_nxt = 1'b0;
              w_state_nxt = S_DATA;
            end
            3'b011: begin
              w_addr_nxt  = w_addr_inc;
              w_we_nxt    = 1'b0;
              w_state_nxt = S_BUS;
            end
            default: w_state_nxt = S_IGNORE;
          endcase
        end
        S_ADDR_HI: begin
          w_addr_nxt[15:8] = rx;
          w_state_nxt      = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          w_addr_nxt[7:0] = rx;
          if (r_is_read) begin
            w_we_nxt    = 1'b0;
            w_state_nxt = S_BUS;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          if (r_burst) w_addr_nxt = w_addr_inc;
          w_wr_data_nxt = rx;
          w_we_nxt      = 1'b1;
          w_state_nxt   = S_BUS;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_CMD_OVERRUN_EN
  logic r_cs_d;
  logic r_overrun;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_d    <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      r_cs_d <= r_cs_s2;
      // Falling synced cs_n marks a new frame and clears the flag.
      if (r_cs_d && !r_cs_s2)
        r_overrun <= 1'b0;
      else if (w_strobe && r_state == S_BUS)
        r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

  assign tx      = r_tx;
  assign addr    = r_addr;
  assign wr_data = r_wr_data;
  assign we      = r_we;
  assign req     = r_req;

endmodule

// File: tb/tb_spi_cmd.sv
// Directed bench for spi_cmd: byte stimulus from a spi_byte stand-in, expected
// bus requests queued as the completing byte is driven and checked when req rises.
module tb_spi_cmd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs_n = 1'b1;
  logic        rx_done = 1'b1;
  logic [7:0]  rx = 8'h00;
  logic [7:0]  tx;
  logic [16:0] addr;
  logic [7:0]  wr_data;
  logic        we;
  logic        req;
  logic        ack = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        overrun;

  typedef struct packed {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_req = 0;
  int   exp_req = 0;
  logic exp_ovr;

  spi_cmd #(.ADDR_WIDTH(17)) dut (
    .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .rx_done(rx_done), .rx(rx),
    .tx(tx), .addr(addr), .wr_data(wr_data), .we(we), .req(req), .ack(ack),
    .rd_data(rd_data), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge req) n_req++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One SPI byte: done falls while bits shift, then rises with rx valid.
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b0;
    tick(4);
    rx = b;
    rx_done = 1'b1;
    tick(6);
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic cs_end();
    tick(2);
    spi_cs_n = 1'b1;
    tick(5);
  endtask

  task automatic push(input logic w, input logic [16:0] a, input logic [7:0] d);
    exp_t e;
    e.we = w; e.addr = a; e.data = d;
    sb_q.push_back(e);
    exp_req++;
  endtask

  task automatic wait_req();
    int n = 0;
    while (req !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    check("req_seen", {31'd0, req}, 32'd1);
    if (req === 1'b1) begin
      check("sb_avail", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        check("req_addr", {15'd0, addr}, {15'd0, cur.addr});
        check("req_we", {31'd0, we}, {31'd0, cur.we});
        if (cur.we) check("req_wdata", {24'd0, wr_data}, {24'd0, cur.data});
      end
    end
  endtask

  task automatic do_bus(input int delay, input logic [7:0] rd);
    wait_req();
    tick(delay);
    check("req_held", {31'd0, req}, 32'd1);
    rd_data = rd;
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("req_drop", {31'd0, req}, 32'd0);
    if (!cur.we) check("tx_rdata", {24'd0, tx}, {24'd0, rd});
  endtask

  initial begin
`ifdef SPI_CMD_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    tick(3);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_addr", {15'd0, addr}, 32'd0);
    check("rst_wdata", {24'd0, wr_data}, 32'd0);
    check("rst_tx", {24'd0, tx}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    tick(2);

    // WRITE_AT 0x12345 <= 0xA5
    cs_start();
    send_byte(8'h01); send_byte(8'h23); send_byte(8'h45);
    push(1'b1, 17'h12345, 8'hA5);
    send_byte(8'hA5);
    do_bus(3, 8'h00);
    cs_end();

    // Burst across the top of the address space
    cs_start();
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
    push(1'b1, 17'h1FFFF, 8'h11);
    send_byte(8'h11);
    do_bus(1, 8'h00);
    push(1'b1, 17'h00000, 8'h22);
    send_byte(8'h22);
    do_bus(2, 8'h00);
    cs_end();

    // READ_AT 0x08000, then a dummy byte that must not start anything
    cs_start();
    send_byte(8'h20); send_byte(8'h80);
    push(1'b0, 17'h08000, 8'h00);
    send_byte(8'h00);
    do_bus(2, 8'h5A);
    send_byte(8'h00);
    check("tx_hold_dummy", {24'd0, tx}, 32'h5A);
    check("no_req_after_read", n_req, exp_req);
    cs_end();

    // READ_NEXT
    cs_start();
    push(1'b0, 17'h08001, 8'h00);
    send_byte(8'h60);
    do_bus(1, 8'h3C);
    cs_end();

    // Undefined command is ignored; WRITE_NEXT afterwards
    cs_start();
    send_byte(8'hE0); send_byte(8'h00); send_byte(8'h00);
    check("undef_no_req", n_req, exp_req);
    cs_end();
    cs_start();
    send_byte(8'h40);
    push(1'b1, 17'h08002, 8'h77);
    send_byte(8'h77);
    do_bus(1, 8'hEE);
    check("tx_hold_write", {24'd0, tx}, 32'h3C);
    cs_end();

    // cs_n raised after ADDR_HI; next frame starts cleanly from IDLE
    cs_start();
    send_byte(8'h01); send_byte(8'h12);
    cs_end();
    check("midaddr_no_req", n_req, exp_req);
    check("midaddr_addr", {15'd0, addr}, 32'h11202);
    cs_start();
    send_byte(8'h40);
    push(1'b1, 17'h11203, 8'h99);
    send_byte(8'h99);
    do_bus(1, 8'h00);
    cs_end();

    // Reset during BUS drops req without waiting for a clock
    cs_start();
    send_byte(8'h40);
    push(1'b1, 17'h11204, 8'h55);
    send_byte(8'h55);
    wait_req();
    #2 reset = 1'b1;
    #1 check("rst_async_req", {31'd0, req}, 32'd0);
    check("rst_async_addr", {15'd0, addr}, 32'd0);
    tick(2);
    reset = 1'b0;
    cs_end();

    // Byte arriving while ack is withheld
    cs_start();
    send_byte(8'h40);
    push(1'b1, 17'h00001, 8'h66);
    send_byte(8'h66);
    wait_req();
    send_byte(8'hAA);
    check("ovr_set", {31'd0, overrun}, {31'd0, exp_ovr});
    check("ovr_req_held", {31'd0, req}, 32'd1);
    check("ovr_wdata_kept", {24'd0, wr_data}, 32'h66);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ovr_req_drop", {31'd0, req}, 32'd0);
    cs_end();
    check("ovr_sticky", {31'd0, overrun}, {31'd0, exp_ovr});
    cs_start();
    check("ovr_clear", {31'd0, overrun}, 32'd0);
    cs_end();

    check("req_total", n_req, exp_req);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
